// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port B between CPU write strobes,
// a bulk loader write stream and a debug read-back port.
module ram_port_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_rvalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_CPU,
      GNT_LD,
      GNT_RD
   } gnt_t;

   typedef enum logic {
      RR_LD,
      RR_RD
   } rr_t;

   logic              cpu_we_q;
   logic              cpu_pend;
   logic              cpu_edge;
   logic [ADDR_W-1:0] cpu_addr_q;
   logic [DATA_W-1:0] cpu_data_q;
   gnt_t              gnt;
   rr_t               rr;
   rr_t               rr_next;
   logic [RD_LATENCY:0] rd_pipe;

   // The CPU holds cpu_we for several RAM clocks; only its rising
   // edge counts as a new write.
   assign cpu_edge = cpu_we & ~cpu_we_q;

   // Capture one CPU write per strobe and hold it until issued.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cpu_we_q   <= 1'b0;
         cpu_pend   <= 1'b0;
         cpu_addr_q <= '0;
         cpu_data_q <= '0;
      end else begin
         cpu_we_q <= cpu_we;
         if (cpu_edge) begin
            cpu_pend   <= 1'b1;
            cpu_addr_q <= cpu_addr;
            cpu_data_q <= cpu_data;
         end else if (gnt == GNT_CPU) begin
            cpu_pend <= 1'b0;
         end
      end
   end

   // Grant: pending CPU write first, else loader/reader with
   // round-robin when both request.
   always_comb begin
      gnt     = GNT_NONE;
      rr_next = rr;
      if (!rst_n) begin
         gnt = GNT_NONE;
      end else if (cpu_pend) begin
         gnt = GNT_CPU;
      end else if (ld_valid && !rd_valid) begin
         gnt = GNT_LD;
      end else if (rd_valid && !ld_valid) begin
         gnt = GNT_RD;
      end else if (ld_valid && rd_valid) begin
         gnt = (rr == RR_LD) ? GNT_LD : GNT_RD;
      end
      if (gnt == GNT_LD) rr_next = RR_RD;
      if (gnt == GNT_RD) rr_next = RR_LD;
   end

   assign ld_ready = (gnt == GNT_LD);
   assign rd_ready = (gnt == GNT_RD);

   // Round-robin pointer between loader and reader.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) rr <= RR_LD;
      else        rr <= rr_next;
   end

   // Register the granted access onto RAM port B.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
      end else begin
         ram_we <= 1'b0;
         unique case (gnt)
            GNT_CPU: begin
               ram_we   <= 1'b1;
               ram_addr <= cpu_addr_q;
               ram_data <= cpu_data_q;
            end
            GNT_LD: begin
               ram_we   <= 1'b1;
               ram_addr <= ld_addr;
               ram_data <= ld_data;
            end
            GNT_RD: begin
               ram_addr <= rd_addr;
            end
            default: ;
         endcase
      end
   end

   // Track in-flight reads: one slot for the address register plus
   // RD_LATENCY slots for the RAM itself.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) rd_pipe <= '0;
      else        rd_pipe <= {rd_pipe[RD_LATENCY-1:0], gnt == GNT_RD};
   end

   assign rd_rvalid = rd_pipe[RD_LATENCY];
   assign rd_data   = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of ram_port_arbiter against
// a behavioural read-after-write RAM with one cycle read latency.
module tb_ram_port_arbiter;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_data = '0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [15:0] ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic        rd_valid = 1'b0;
   logic        rd_ready;
   logic [15:0] rd_addr = '0;
   logic [7:0]  rd_data;
   logic        rd_rvalid;
   logic [15:0] ram_addr;
   logic [7:0]  ram_data;
   logic        ram_we;
   logic [7:0]  ram_q = '0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:65535];
   logic        mon_en = 1'b0;
   logic [15:0] ld_seen = '0;
   logic [15:0] cpu_seen = '0;
   int          ld_bad = 0;
   int          cpu_bad = 0;

   ram_port_arbiter #(
      .ADDR_W(16), .DATA_W(8), .RD_LATENCY(1)
   ) dut (
      .clock(clock), .rst_n(rst_n),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_rvalid(rd_rvalid),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
      .ram_q(ram_q)
   );

   always #5 clock = ~clock;

   // Port B RAM model: write then registered read of the same cycle.
   always @(posedge clock) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   // Port B write monitor for the streaming phase.
   always @(negedge clock) begin
      if (mon_en && ram_we) begin
         if (ram_addr[15]) begin
            if (ram_addr !== (16'h8000 + cpu_seen) ||
                ram_data !== cpu_seen[7:0]) cpu_bad++;
            cpu_seen++;
         end else begin
            if (ram_addr !== ld_seen ||
                ram_data !== (ld_seen[7:0] ^ 8'h3C)) ld_bad++;
            ld_seen++;
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int pulses;
      int first;
      logic [15:0] p_addr;
      logic [7:0]  p_data;
      int idx;
      int c;
      int edges;
      logic hs;

      // Reset
      tick;
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_data", 32'(ram_data), 0);
      chk("rst_ldr", 32'(ld_ready), 0);
      chk("rst_rdr", 32'(rd_ready), 0);
      chk("rst_rvalid", 32'(rd_rvalid), 0);
      tick;
      rst_n = 1'b1;
      tick;

      // CPU level held 16 cycles -> one write, 2 cycles after edge
      cpu_we = 1'b1;
      cpu_addr = 16'h1234;
      cpu_data = 8'h5A;
      pulses = 0;
      first = -1;
      p_addr = '0;
      p_data = '0;
      for (int k = 1; k <= 18; k++) begin
         tick;
         if (k == 16) cpu_we = 1'b0;
         if (ram_we) begin
            pulses++;
            if (first < 0) begin
               first = k;
               p_addr = ram_addr;
               p_data = ram_data;
            end
         end
      end
      chk("cpu_pulses", 32'(pulses), 1);
      chk("cpu_delay", 32'(first), 2);
      chk("cpu_addr", 32'(p_addr), 32'h1234);
      chk("cpu_data", 32'(p_data), 32'h5A);

      // Loader and reader both requesting: L,R,L,R...
      for (int i = 0; i < 10; i++) begin
         ld_valid = (i < 8);
         rd_valid = (i < 8);
         ld_addr = 16'h0200 + 16'(i);
         ld_data = 8'(i);
         rd_addr = 16'h0200;
         #1;
         chk("alt_rvalid", 32'(rd_rvalid),
             32'(i == 3 || i == 5 || i == 7 || i == 9));
         if (i < 8) begin
            chk("alt_ldr", 32'(ld_ready), 32'(i % 2 == 0));
            chk("alt_rdr", 32'(rd_ready), 32'(i % 2 == 1));
            chk("alt_excl", 32'(ld_ready & rd_ready), 0);
         end
         tick;
      end

      // Loader stream with a CPU edge every 4 cycles
      mon_en = 1'b1;
      idx = 0;
      c = 0;
      edges = 0;
      while (idx < 256 && c < 2000) begin
         if (c % 4 == 0) edges++;
         cpu_we = (c % 4 < 2);
         cpu_addr = 16'h8000 + 16'(edges - 1);
         cpu_data = 8'(edges - 1);
         ld_valid = 1'b1;
         ld_addr = 16'(idx);
         ld_data = 8'(idx) ^ 8'h3C;
         #1;
         chk("str_ldr", 32'(ld_ready), 32'(c % 4 != 1));
         hs = ld_ready;
         tick;
         if (hs) idx++;
         c++;
      end
      ld_valid = 1'b0;
      cpu_we = 1'b0;
      repeat (4) tick;
      mon_en = 1'b0;
      chk("str_done", 32'(idx), 256);
      chk("str_ld_cnt", 32'(ld_seen), 256);
      chk("str_ld_bad", 32'(ld_bad), 0);
      chk("str_cpu_cnt", 32'(cpu_seen), 32'(edges));
      chk("str_cpu_bad", 32'(cpu_bad), 0);

      // Loader write then reader read of the same address
      ld_valid = 1'b1;
      ld_addr = 16'h0100;
      ld_data = 8'hA5;
      #1;
      chk("raw_ldr", 32'(ld_ready), 1);
      tick;
      ld_valid = 1'b0;
      rd_valid = 1'b1;
      rd_addr = 16'h0100;
      #1;
      chk("raw_rdr", 32'(rd_ready), 1);
      tick;
      rd_valid = 1'b0;
      chk("raw_early", 32'(rd_rvalid), 0);
      tick;
      chk("raw_rvalid", 32'(rd_rvalid), 1);
      chk("raw_data", 32'(rd_data), 32'hA5);
      tick;
      chk("raw_once", 32'(rd_rvalid), 0);

      // Preload 0x10..0x12 with 1,2,3 then read back-to-back
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_addr = 16'h0010 + 16'(i);
         ld_data = 8'(i + 1);
         tick;
      end
      ld_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd_valid = (i < 3);
         rd_addr = 16'h0010 + 16'(i);
         #1;
         if (i < 3) chk("b2b_rdr", 32'(rd_ready), 1);
         chk("b2b_rvalid", 32'(rd_rvalid), 32'(i >= 2 && i <= 4));
         if (i >= 2 && i <= 4) chk("b2b_data", 32'(rd_data), 32'(i - 1));
         tick;
      end

      // Reset while two reads are in flight
      rd_valid = 1'b1;
      rd_addr = 16'h0010;
      #1;
      chk("ifl_rdr0", 32'(rd_ready), 1);
      tick;
      rd_addr = 16'h0011;
      #1;
      chk("ifl_rdr1", 32'(rd_ready), 1);
      rst_n = 1'b0;
      rd_valid = 1'b0;
      #1;
      chk("ifl_we", 32'(ram_we), 0);
      chk("ifl_addr", 32'(ram_addr), 0);
      chk("ifl_data", 32'(ram_data), 0);
      chk("ifl_ldr", 32'(ld_ready), 0);
      chk("ifl_rdr", 32'(rd_ready), 0);
      chk("ifl_rvalid", 32'(rd_rvalid), 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("ifl_hold", 32'(rd_rvalid), 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("ifl_after", 32'(rd_rvalid), 0);
      end
      ld_valid = 1'b1;
      ld_addr = 16'h0300;
      ld_data = 8'h77;
      #1;
      chk("post_ldr", 32'(ld_ready), 1);
      tick;
      ld_valid = 1'b0;
      chk("post_we", 32'(ram_we), 1);
      chk("post_addr", 32'(ram_addr), 32'h0300);
      chk("post_data", 32'(ram_data), 32'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares write/read port B of the dual-port program RAM between three requesters.
- Requester 0: gigatron CPU write strobe; highest priority; never dropped.
- Requester 1: bulk loader write stream, e.g. the SD/PS2 program loader.
- Requester 2: debug read-back port.
- Sits between the gigatron core and the RAM on the 100 MHz RAM clock. Port A stays a direct CPU read path.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LATENCY, 1, cycles from ram_addr registered to ram_q valid (must be ≥1).

Ports:
- clock  in  1  RAM clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_we  in  1  CPU write enable; level, may span many clock cycles (slower CPU clock).
- cpu_addr  in  ADDR_W  CPU write address, stable while cpu_we=1.
- cpu_data  in  DATA_W  CPU write data, stable while cpu_we=1.
- ld_valid  in  1  loader request.
- ld_ready  out  1  loader accept.
- ld_addr  in  ADDR_W  loader address.
- ld_data  in  DATA_W  loader data.
- rd_valid  in  1  debug read request.
- rd_ready  out  1  debug read accept.
- rd_addr  in  ADDR_W  debug read address.
- rd_data  out  DATA_W  read data.
- rd_rvalid  out  1  rd_data valid strobe.
- ram_addr  out  ADDR_W  RAM port B address (registered).
- ram_data  out  DATA_W  RAM port B write data (registered).
- ram_we  out  1  RAM port B write enable (registered).
- ram_q  in  DATA_W  RAM port B read data.

Behaviour:
- Reset (async, rst_n=0):
  - ram_we=0, ram_addr=0, ram_data=0, ld_ready=0, rd_ready=0, rd_rvalid=0.
  - CPU pending flag cleared, cpu_we_q=0, round-robin pointer = loader.
  - Read-tracking pipe cleared: in-flight reads are discarded, with no rvalid after reset.
- CPU capture:
  - cpu_we_q registers cpu_we.
  - A rising edge (cpu_we=1, cpu_we_q=0) latches cpu_addr/cpu_data and sets cpu_pend.
  - A level held high produces exactly one write.
  - Edges are ≥2 cycles apart and cpu_pend always clears the next cycle, so no overflow path exists.
- Grant, evaluated each cycle combinationally from current state:
  - If cpu_pend: grant CPU; ld_ready=rd_ready=0.
  - Else if exactly one of ld_valid/rd_valid is set: grant it.
  - Else if both are set: grant the requester at the rr pointer.
  - The rr pointer flips to the other requester after any loader or reader grant. A CPU grant or an idle cycle leaves it unchanged.
  - ld_ready = ld_valid & loader granted; rd_ready = rd_valid & reader granted. Both are combinational.
  - A transfer occurs when valid & ready.
- Issue (next clock edge after the grant):
  - CPU grant: ram_addr=cpu addr, ram_data=cpu data, ram_we=1; cpu_pend cleared.
  - Loader: ram_addr=ld_addr, ram_data=ld_data, ram_we=1.
  - Reader: ram_addr=rd_addr, ram_we=0, ram_data holds its value; a 1 is pushed into the read-tracking pipe.
  - No grant: ram_we=0; ram_addr and ram_data hold their values.
- Read return:
  - Read handshake in cycle T → rd_rvalid=1 for exactly one cycle in cycle T+1+RD_LATENCY.
  - rd_data = ram_q, pass-through; it is valid only while rd_rvalid=1.
  - Back-to-back reads are fully pipelined, one rvalid per accepted read, in order.
- Throughput and starvation:
  - One port-B access per cycle.
  - The CPU occupies at most 1 of every 2 cycles.
  - Loader and reader each get ≥1 grant in every 4 cycles while requesting.
- Simultaneous events:
  - A CPU edge in the same cycle as ld_valid/rd_valid: this cycle's grant uses the old cpu_pend=0, so the loader/reader is granted now. The CPU is granted the following cycle.
- Ordering: write-then-read to the same address in consecutive grants returns the new data. The RAM is configured read-after-write on port B.

Test Plan:
- Reset, then cpu_we held high 16 cycles with addr 0x1234, data 0x5A → exactly one ram_we pulse, ram_addr=0x1234, ram_data=0x5A, 2 cycles after the edge.
- ld_valid and rd_valid held high continuously, CPU idle → grants alternate L,R,L,R; ld_ready/rd_ready never both 1; each read yields rd_rvalid 2 cycles after its handshake (RD_LATENCY=1).
- Loader streams 0x0000..0x00FF while the CPU produces a rising edge every 4 cycles → all 256 loader writes plus every CPU write appear on port B; no loader write during a CPU-issue cycle; no CPU write lost.
- Write 0xA5 to 0x0100 via loader, then read 0x0100 via reader on the next grant → rd_data=0xA5 with rd_rvalid.
- Three back-to-back reads of 0x10, 0x11, 0x12 (RAM holding 1, 2, 3) → rd_rvalid high 3 consecutive cycles with data 1, 2, 3.
- rst_n pulsed low while 2 reads are in flight → no rd_rvalid afterwards; all outputs 0; the first request after release is granted normally.
